// File: rtl/arb_grant_forwarder.sv
// arb_grant_forwarder
//   Takes a one-hot grant from an upstream round-robin arbiter, accepts the
//   granted port's payload and queues {port, payload} in a small FIFO that
//   drains towards a ready/valid consumer.
//
//   Optional feature macro: ARB_FWD_ERR_CNT_EN
//     defined   -> err_cnt counts clocks with an illegal (multi-hot) grant,
//                  saturating at 255.
//     undefined -> err_cnt is tied to 0 and no counter is built.

// Per-port slice: qualifies the port by its grant bit and returns the
// port's contribution to the selected payload/index, plus its accept.
module arb_grant_forwarder_lane #(
   parameter int          DATA_W = 8,
   parameter int          PW     = 2,
   parameter int unsigned IDX    = 0
) (
   input  logic              gnt,
   input  logic              valid,
   input  logic [DATA_W-1:0] data,
   input  logic              push,
   output logic              ack,
   output logic              sel_valid,
   output logic [DATA_W-1:0] sel_data,
   output logic [PW-1:0]     sel_idx
);

   // Masked contribution; non-granted lanes present all-zero so the
   // parent can OR-reduce across lanes.
   always_comb begin
      sel_valid = gnt & valid;
      sel_data  = gnt ? data : '0;
      sel_idx   = gnt ? PW'(IDX) : '0;
      ack       = gnt & push;
   end

endmodule

module arb_grant_forwarder #(
   parameter int NUM_PORTS = 4,
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_PORTS-1:0]          src_valid,
   input  logic [NUM_PORTS*DATA_W-1:0]   src_data,
   input  logic [NUM_PORTS-1:0]          gnt_i,
   output logic [NUM_PORTS-1:0]          src_ack,
   output logic                          out_valid,
   output logic [DATA_W-1:0]             out_data,
   output logic [$clog2(NUM_PORTS)-1:0]  out_port,
   input  logic                          out_ready,
   output logic [7:0]                    err_cnt
);

   localparam int PW = $clog2(NUM_PORTS);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef struct packed {
      logic [PW-1:0]     port;
      logic [DATA_W-1:0] data;
   } entry_t;

   logic [NUM_PORTS-1:0]             lane_valid;
   logic [NUM_PORTS-1:0][DATA_W-1:0] lane_data;
   logic [NUM_PORTS-1:0][PW-1:0]     lane_idx;

   logic [3:0]        gnt_cnt;
   logic              gnt_legal;
   logic              sel_valid;
   entry_t            sel_entry;

   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [CW-1:0]     count;
   logic              full;
   logic              push;
   logic              pop;
   entry_t            mem [DEPTH];

   // Per-port qualification slices
   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_lane
      arb_grant_forwarder_lane #(
         .DATA_W (DATA_W),
         .PW     (PW),
         .IDX    (p)
      ) u_lane (
         .gnt       (gnt_i[p]),
         .valid     (src_valid[p]),
         .data      (src_data[p*DATA_W +: DATA_W]),
         .push      (push),
         .ack       (src_ack[p]),
         .sel_valid (lane_valid[p]),
         .sel_data  (lane_data[p]),
         .sel_idx   (lane_idx[p])
      );
   end

   // Grant population count: exactly one bit set is a legal grant
   always_comb begin
      gnt_cnt = '0;
      for (int p = 0; p < NUM_PORTS; p++)
         gnt_cnt = gnt_cnt + 4'(gnt_i[p]);
      gnt_legal = (gnt_cnt == 4'd1);
   end

   // OR-reduce lane contributions; only the granted lane is non-zero when
   // the grant is legal, so this yields the granted port's payload/index.
   always_comb begin
      sel_valid = 1'b0;
      sel_entry = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         sel_valid      = sel_valid | lane_valid[p];
         sel_entry.data = sel_entry.data | lane_data[p];
         sel_entry.port = sel_entry.port | lane_idx[p];
      end
   end

   // Handshake: a full FIFO still accepts when the head leaves on the same
   // edge. Reset gates push so src_ack drops immediately with reset.
   always_comb begin
      full      = (count == CW'(DEPTH));
      out_valid = (count != '0);
      pop       = out_valid & out_ready;
      push      = ~reset & gnt_legal & sel_valid & (~full | pop);
   end

   // Payload storage; not reset, stale entries are unreachable via count
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= sel_entry;
   end

   // Head of FIFO straight from registered storage, no bypass
   always_comb begin
      out_data = mem[rd_ptr].data;
      out_port = mem[rd_ptr].port;
   end

   // Pointers and occupancy; pointers wrap naturally at DEPTH (power of 2)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

`ifdef ARB_FWD_ERR_CNT_EN
   logic       gnt_illegal;
   logic [7:0] err_q;

   always_comb gnt_illegal = (gnt_cnt > 4'd1);

   // Saturating count of clocks that saw a multi-hot grant
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         err_q <= '0;
      else if (gnt_illegal && (err_q != 8'hFF))
         err_q <= err_q + 8'd1;
   end

   assign err_cnt = err_q;
`else
   assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_arb_grant_forwarder.sv
// Directed bench for arb_grant_forwarder with a scoreboard queue: stimulus
// pushes the expected {port, data} whenever it expects an accept, and a
// negedge monitor pops/compares on every FIFO handshake.
module tb_arb_grant_forwarder;

   localparam int NP    = 4;
   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int PW    = 2;

   logic               clk = 1'b0;
   logic               reset;
   logic [NP-1:0]      src_valid;
   logic [NP*DW-1:0]   src_data;
   logic [NP-1:0]      gnt_i;
   logic [NP-1:0]      src_ack;
   logic               out_valid;
   logic [DW-1:0]      out_data;
   logic [PW-1:0]      out_port;
   logic               out_ready;
   logic [7:0]         err_cnt;

   int total = 0;
   int bad   = 0;

   logic [PW+DW-1:0] exp_q [$];
   logic [PW+DW-1:0] mon_e;

`ifdef ARB_FWD_ERR_CNT_EN
   localparam logic [7:0] ERR3   = 8'd3;
   localparam logic [7:0] ERRSAT = 8'd255;
`else
   localparam logic [7:0] ERR3   = 8'd0;
   localparam logic [7:0] ERRSAT = 8'd0;
`endif

   arb_grant_forwarder #(
      .NUM_PORTS (NP),
      .DATA_W    (DW),
      .DEPTH     (DEPTH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .src_valid (src_valid),
      .src_data  (src_data),
      .gnt_i     (gnt_i),
      .src_ack   (src_ack),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_port  (out_port),
      .out_ready (out_ready),
      .err_cnt   (err_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_data(input int p, input logic [DW-1:0] v);
      src_data[p*DW +: DW] = v;
   endtask

   task automatic expect_push(input int p, input logic [DW-1:0] v);
      exp_q.push_back({PW'(p), v});
   endtask

   task automatic drain();
      for (int i = 0; i < 50 && (exp_q.size() != 0 || out_valid); i++)
         tick();
      chk("drain_queue_empty", exp_q.size(), 0);
      chk("drain_out_valid", out_valid, 0);
   endtask

   // Monitor: every handshake must match the oldest expected entry
   always @(negedge clk) begin
      if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out: got port %0d data 0x%0h, want no output", out_port, out_data);
         end else begin
            mon_e = exp_q.pop_front();
            chk("out_data", out_data, mon_e[DW-1:0]);
            chk("out_port", out_port, mon_e[DW +: PW]);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      reset     = 1'b1;
      gnt_i     = 4'b0001;
      src_valid = 4'b0001;
      src_data  = '0;
      set_data(0, 8'hA5);
      out_ready = 1'b1;
      #3;
      // Reset state, ack gated by reset even with a legal request
      chk("rst_out_valid", out_valid, 0);
      chk("rst_src_ack", src_ack, 0);
      chk("rst_err_cnt", err_cnt, 0);

      // Single push right after reset release
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("first_ack", src_ack, 4'b0001);
      expect_push(0, 8'hA5);
      tick();
      chk("first_out_valid", out_valid, 1);
      chk("first_out_data", out_data, 8'hA5);
      chk("first_out_port", out_port, 0);
      gnt_i = '0; src_valid = '0;
      drain();

      // Fill to full with rotating grant, fifth request stalls
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         gnt_i     = 4'b0001 << (i % 4);
         src_valid = 4'b1111;
         for (int p = 0; p < NP; p++) set_data(p, 8'h10 + 8'(i));
         #1;
         if (i < 4) begin
            chk("fill_ack", src_ack, gnt_i);
            expect_push(i % 4, 8'h10 + 8'(i));
            tick();
         end else begin
            chk("full_ack_low", src_ack, 4'b0000);
         end
      end
      chk("full_head_valid", out_valid, 1);
      chk("full_head_data", out_data, 8'h10);
      // Held request goes in once the head leaves on the same edge
      out_ready = 1'b1;
      #1;
      chk("full_pop_push_ack", src_ack, 4'b0001);
      expect_push(0, 8'h14);
      tick();
      gnt_i = '0; src_valid = '0;
      drain();

      // Full FIFO, simultaneous push and pop keeps count at DEPTH
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         gnt_i = 4'b0001 << i;
         src_valid = 4'b1111;
         set_data(i, 8'h20 + 8'(i));
         #1;
         chk("refill_ack", src_ack, gnt_i);
         expect_push(i, 8'h20 + 8'(i));
         tick();
      end
      gnt_i = 4'b0100;
      set_data(2, 8'h3C);
      out_ready = 1'b1;
      #1;
      chk("pushpop_ack", src_ack, 4'b0100);
      expect_push(2, 8'h3C);
      tick();
      out_ready = 1'b0;
      gnt_i = 4'b0001;
      set_data(0, 8'h55);
      #1;
      chk("still_full_ack", src_ack, 4'b0000);
      gnt_i = '0; src_valid = '0; out_ready = 1'b1;
      drain();

      // Granted port without valid: nothing happens
      gnt_i = 4'b0010; src_valid = 4'b0000;
      #1;
      chk("novalid_ack", src_ack, 4'b0000);
      tick();
      chk("novalid_out_valid", out_valid, 0);

      // Illegal grant for 3 clocks
      gnt_i = 4'b0011; src_valid = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("illegal_ack", src_ack, 4'b0000);
         tick();
      end
      gnt_i = '0;
      #1;
      chk("illegal_err_cnt3", err_cnt, ERR3);
      chk("illegal_no_push", out_valid, 0);

      // Long illegal grant saturates the counter
      gnt_i = 4'b1111;
      for (int i = 0; i < 300; i++) tick();
      gnt_i = '0;
      #1;
      chk("err_cnt_sat", err_cnt, ERRSAT);
      chk("sat_no_push", out_valid, 0);

      // Asynchronous reset with two entries queued
      out_ready = 1'b0;
      src_valid = 4'b1111;
      gnt_i = 4'b0001; set_data(0, 8'h61);
      #1;
      chk("pre_rst_ack0", src_ack, 4'b0001);
      tick();
      gnt_i = 4'b0010; set_data(1, 8'h62);
      #1;
      chk("pre_rst_ack1", src_ack, 4'b0010);
      tick();
      gnt_i = 4'b0100;
      set_data(2, 8'h77);
      chk("pre_rst_out_valid", out_valid, 1);
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst_out_valid", out_valid, 0);
      chk("async_rst_err_cnt", err_cnt, 0);
      chk("async_rst_ack", src_ack, 4'b0000);
      @(posedge clk);
      @(negedge clk);
      #2;
      reset = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("post_rst_ack", src_ack, 4'b0100);
      expect_push(2, 8'h77);
      tick();
      chk("post_rst_out_valid", out_valid, 1);
      chk("post_rst_out_data", out_data, 8'h77);
      gnt_i = '0; src_valid = '0;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
